csr_ctrl: RTL and testbench

- Machine-mode CSR controller for the single-cycle RV32 core.
- Holds the machine CSRs and performs csrrw/csrrs/csrrc (register and immediate forms) as a read-modify-write.
- Sequences trap entry (ecall, illegal CSR access, external interrupt) and mret.
- Supplies the PC redirect to fetch.
- Sits beside the register file; driven by the decoder in the same cycle the instruction executes.

---
 rtl/csr_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_csr_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_ctrl.sv
// Machine-mode CSR controller for the single-cycle RV32 core: CSR read-modify-write,
// trap entry / mret sequencing, cycle/instret counters and the fetch redirect.
module csr_ctrl #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] HART_ID     = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic        csr_en,
  input  logic [2:0]  funct3,
  input  logic [11:0] csr_addr,
  input  logic [31:0] rs1_data,
  input  logic [4:0]  rs1_field,
  input  logic [31:0] pc,
  input  logic        ecall,
  input  logic        mret,
  input  logic        ext_irq,
  output logic [31:0] csr_rdata,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        trap_taken
);

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_RW   = 2'd1,
    OP_RS   = 2'd2,
    OP_RC   = 2'd3
  } csr_op_e;

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_CYCLE     = 12'hC00;
  localparam logic [11:0] A_CYCLEH    = 12'hC80;
  localparam logic [11:0] A_INSTRET   = 12'hC02;
  localparam logic [11:0] A_INSTRETH  = 12'hC82;
  localparam logic [11:0] A_MHARTID   = 12'hF14;

  localparam logic [31:0] CAUSE_IRQ     = 32'h8000_000B;
  localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
  localparam logic [31:0] CAUSE_ECALL   = 32'd11;
  localparam logic [31:0] ALIGN_MASK    = 32'hFFFF_FFFC;

  logic        r_mie;
  logic        r_mpie;
  logic        r_meie;
  logic [31:0] r_mtvec;
  logic [31:0] r_mscratch;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;
  logic [63:0] r_mcycle;
  logic [63:0] r_minstret;

  csr_op_e     w_op;
  logic [31:0] w_b;
  logic [31:0] w_old;
  logic [31:0] w_new;
  logic [31:0] w_cause;
  logic        w_impl;
  logic        w_active;
  logic        w_wr_attempt;
  logic        w_illegal;
  logic        w_irq;
  logic        w_ecall;
  logic        w_trap;
  logic        w_mret;
  logic        w_we;
  logic        w_retire;
  logic [63:0] w_cycle_inc;
  logic [63:0] w_instret_inc;

  assign w_op     = csr_op_e'(funct3[1:0]);
  assign w_b      = funct3[2] ? {27'd0, rs1_field} : rs1_data;
  assign w_active = csr_en & instr_valid;

  // NOTE: defaults first, so addresses missing from the case cannot infer a latch.
  always_comb begin
    w_old  = '0;
    w_impl = 1'b1;
    case (csr_addr)
      A_MSTATUS:               w_old = {19'd0, 2'b11, 3'd0, r_mpie, 3'd0, r_mie, 3'd0};
      A_MIE:                   w_old = {20'd0, r_meie, 11'd0};
      A_MTVEC:                 w_old = r_mtvec;
      A_MSCRATCH:              w_old = r_mscratch;
      A_MEPC:                  w_old = r_mepc;
      A_MCAUSE:                w_old = r_mcause;
      A_MIP:                   w_old = {20'd0, ext_irq, 11'd0};
      A_MCYCLE,   A_CYCLE:     w_old = r_mcycle[31:0];
      A_MCYCLEH,  A_CYCLEH:    w_old = r_mcycle[63:32];
      A_MINSTRET, A_INSTRET:   w_old = r_minstret[31:0];
      A_MINSTRETH, A_INSTRETH: w_old = r_minstret[63:32];
      A_MHARTID:               w_old = HART_ID;
      default:                 w_impl = 1'b0;
    endcase
  end

  always_comb begin
    w_new = w_b;
    case (w_op)
      OP_RS:   w_new = w_old | w_b;
      OP_RC:   w_new = w_old & ~w_b;
      default: w_new = w_b;
    endcase
  end

  // Set/clear with a zero operand is a pure read, so read-only addresses stay legal.
  assign w_wr_attempt = (w_op == OP_RW) |
                        (((w_op == OP_RS) | (w_op == OP_RC)) & (rs1_field != 5'd0));
  assign w_illegal    = w_active & (~w_impl | (w_op == OP_NONE) |
                                    (w_wr_attempt & (csr_addr[11:10] == 2'b11)));
  assign w_irq        = r_mie & r_meie & ext_irq & instr_valid;
  assign w_ecall      = ecall & instr_valid;
  assign w_trap       = w_irq | w_illegal | w_ecall;
  assign w_cause      = w_irq ? CAUSE_IRQ : (w_illegal ? CAUSE_ILLEGAL : CAUSE_ECALL);
  assign w_mret       = mret & instr_valid & ~w_trap;
  assign w_we         = w_active & w_wr_attempt & ~w_trap;
  assign w_retire     = instr_valid & ~w_trap;

  assign w_cycle_inc   = r_mcycle + 64'd1;
  assign w_instret_inc = r_minstret + 64'd1;

  // NOTE: non-blocking assignments so every register samples pre-edge values together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mie      <= 1'b0;
      r_mpie     <= 1'b0;
      r_meie     <= 1'b0;
      r_mtvec    <= MTVEC_RESET & ALIGN_MASK;
      r_mscratch <= '0;
      r_mepc     <= '0;
      r_mcause   <= '0;
      r_mcycle   <= '0;
      r_minstret <= '0;
    end else begin
      if (w_trap) begin
        r_mpie <= r_mie;
        r_mie  <= 1'b0;
      end else if (w_mret) begin
        r_mie  <= r_mpie;
        r_mpie <= 1'b1;
      end else if (w_we && csr_addr == A_MSTATUS) begin
        r_mie  <= w_new[3];
        r_mpie <= w_new[7];
      end

      if (w_we && csr_addr == A_MIE)      r_meie     <= w_new[11];
      if (w_we && csr_addr == A_MTVEC)    r_mtvec    <= w_new & ALIGN_MASK;
      if (w_we && csr_addr == A_MSCRATCH) r_mscratch <= w_new;

      if (w_trap) begin
        r_mepc   <= pc & ALIGN_MASK;
        r_mcause <= w_cause;
      end else begin
        if (w_we && csr_addr == A_MEPC)   r_mepc   <= w_new & ALIGN_MASK;
        if (w_we && csr_addr == A_MCAUSE) r_mcause <= w_new;
      end

      // A written half replaces its increment; the other half never sees that cycle's carry.
      if (w_we && csr_addr == A_MCYCLE)
        r_mcycle <= {r_mcycle[63:32], w_new};
      else if (w_we && csr_addr == A_MCYCLEH)
        r_mcycle <= {w_new, w_cycle_inc[31:0]};
      else
        r_mcycle <= w_cycle_inc;

      if (w_we && csr_addr == A_MINSTRET)
        r_minstret <= {r_minstret[63:32], w_new};
      else if (w_we && csr_addr == A_MINSTRETH)
        r_minstret <= {w_new, w_instret_inc[31:0]};
      else if (w_retire)
        r_minstret <= w_instret_inc;
    end
  end

  assign csr_rdata   = (~rst & w_active) ? w_old : '0;
  assign trap_taken  = ~rst & w_trap;
  assign redirect    = ~rst & (w_trap | w_mret);
  assign redirect_pc = rst    ? '0      :
                       w_trap ? r_mtvec :
                       w_mret ? r_mepc  : '0;

endmodule

// File: tb/tb_csr_ctrl.sv
// Scoreboard bench for csr_ctrl: a driver pushes expected responses computed from a
// behavioural CSR model; a negedge monitor pops and compares them against the DUT.
module tb_csr_ctrl;

  localparam logic [31:0] MTVEC_RST = 32'h0000_1003;
  localparam logic [31:0] HART      = 32'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid, csr_en, ecall, mret, ext_irq;
  logic [2:0]  funct3;
  logic [11:0] csr_addr;
  logic [31:0] rs1_data, pc;
  logic [4:0]  rs1_field;
  logic [31:0] csr_rdata, redirect_pc;
  logic        redirect, trap_taken;

  csr_ctrl #(.MTVEC_RESET(MTVEC_RST), .HART_ID(HART)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .csr_en(csr_en),
    .funct3(funct3), .csr_addr(csr_addr), .rs1_data(rs1_data), .rs1_field(rs1_field),
    .pc(pc), .ecall(ecall), .mret(mret), .ext_irq(ext_irq),
    .csr_rdata(csr_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .trap_taken(trap_taken)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        iv;
    logic        ce;
    logic [2:0]  f3;
    logic [11:0] addr;
    logic [31:0] d;
    logic [4:0]  fld;
    logic [31:0] pc;
    logic        ec;
    logic        mr;
    logic        irq;
  } stim_t;

  typedef struct {
    logic [31:0] rdata;
    logic        redirect;
    logic [31:0] rpc;
    logic        trap;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;
  logic [31:0] g_pc = 32'h0000_0400;

  // Behavioural architectural state.
  logic        m_mie, m_mpie, m_meie;
  logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause;
  logic [63:0] m_cyc, m_inst;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic m_reset();
    m_mie = 0; m_mpie = 0; m_meie = 0;
    m_mtvec = MTVEC_RST & ~32'd3;
    m_mscratch = 0; m_mepc = 0; m_mcause = 0;
    m_cyc = 0; m_inst = 0;
  endtask

  function automatic logic m_impl(input logic [11:0] a);
    case (a)
      12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344,
      12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82,
      12'hF14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a, input logic irq);
    case (a)
      12'h300: return 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
      12'h304: return 32'(m_meie) << 11;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h344: return 32'(irq) << 11;
      12'hB00, 12'hC00: return m_cyc[31:0];
      12'hB80, 12'hC80: return m_cyc[63:32];
      12'hB02, 12'hC02: return m_inst[31:0];
      12'hB82, 12'hC82: return m_inst[63:32];
      12'hF14: return HART;
      default: return 32'd0;
    endcase
  endfunction

  // Drive one cycle, predict its response, advance the model to the post-edge state.
  task automatic step(input stim_t s, input string tag);
    exp_t        e;
    logic [1:0]  op;
    logic [31:0] b, old, nv, cause;
    logic        act, wr, illegal, intr, trp;
    logic [63:0] cyc_n, inst_n;
    rst = s.rst; instr_valid = s.iv; csr_en = s.ce; funct3 = s.f3; csr_addr = s.addr;
    rs1_data = s.d; rs1_field = s.fld; pc = s.pc; ecall = s.ec; mret = s.mr; ext_irq = s.irq;
    e.tag = tag;
    if (s.rst) begin
      e.rdata = 0; e.redirect = 0; e.rpc = 0; e.trap = 0;
      m_reset();
    end else begin
      op      = s.f3[1:0];
      b       = s.f3[2] ? {27'd0, s.fld} : s.d;
      act     = s.ce && s.iv;
      wr      = (op == 2'd1) || (op != 2'd0 && s.fld != 5'd0);
      old     = m_read(s.addr, s.irq);
      illegal = act && (!m_impl(s.addr) || op == 2'd0 || (wr && s.addr[11:10] == 2'b11));
      intr    = m_mie && m_meie && s.irq && s.iv;
      trp     = intr || illegal || (s.ec && s.iv);
      cause   = intr ? 32'h8000_000B : (illegal ? 32'd2 : 32'd11);
      e.rdata    = act ? old : 32'd0;
      e.trap     = trp;
      e.redirect = trp || (s.mr && s.iv);
      e.rpc      = trp ? m_mtvec : m_mepc;

      cyc_n  = m_cyc + 64'd1;
      inst_n = (s.iv && !trp) ? m_inst + 64'd1 : m_inst;
      if (trp) begin
        m_mepc = s.pc & ~32'd3; m_mcause = cause; m_mpie = m_mie; m_mie = 0;
      end else if (s.iv) begin
        if (s.mr) begin
          m_mie = m_mpie; m_mpie = 1;
        end
        if (act && wr) begin
          nv = (op == 2'd1) ? b : (op == 2'd2) ? (old | b) : (old & ~b);
          case (s.addr)
            12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
            12'h304: m_meie = nv[11];
            12'h305: m_mtvec = nv & ~32'd3;
            12'h340: m_mscratch = nv;
            12'h341: m_mepc = nv & ~32'd3;
            12'h342: m_mcause = nv;
            12'hB00: cyc_n = {m_cyc[63:32], nv};
            12'hB80: cyc_n = {nv, m_cyc[31:0] + 32'd1};
            12'hB02: inst_n = {m_inst[63:32], nv};
            12'hB82: inst_n = {nv, m_inst[31:0] + 32'd1};
            default: ;
          endcase
        end
      end
      m_cyc = cyc_n; m_inst = inst_n;
    end
    sb.push_back(e);
    g_pc = g_pc + 32'd4;
    @(posedge clk); #1;
  endtask

  task automatic do_csr(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] d,
                        input logic [4:0] fld, input logic irq, input string tag);
    stim_t s;
    s = '0; s.iv = 1; s.ce = 1; s.f3 = f3; s.addr = a; s.d = d; s.fld = fld;
    s.irq = irq; s.pc = g_pc;
    step(s, tag);
  endtask

  task automatic do_rd(input logic [11:0] a, input string tag);
    do_csr(3'd2, a, 32'hFFFF_FFFF, 5'd0, 1'b0, tag);
  endtask

  task automatic do_sys(input logic ec, input logic mr, input logic [31:0] p,
                        input logic irq, input logic iv, input string tag);
    stim_t s;
    s = '0; s.iv = iv; s.ec = ec; s.mr = mr; s.pc = p; s.irq = irq;
    step(s, tag);
  endtask

  task automatic do_rst(input string tag);
    stim_t s;
    s = '0; s.rst = 1; s.iv = 1; s.ce = 1; s.f3 = 3'd1; s.addr = 12'h340;
    s.d = 32'h1234_5678; s.fld = 5'd1; s.mr = 1; s.irq = 1;
    step(s, tag);
  endtask

  // Monitor: every cycle the DUT presents a response; compare it with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.tag, ".trap"},     32'(trap_taken), 32'(e.trap));
        check({e.tag, ".redirect"}, 32'(redirect),   32'(e.redirect));
        check({e.tag, ".rdata"},    csr_rdata,       e.rdata);
        if (e.redirect) check({e.tag, ".rpc"}, redirect_pc, e.rpc);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] addrs [18];
    stim_t s;
    addrs = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344, 12'hB00,
              12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'hF14,
              12'h7FF, 12'h301};
    rst = 1; instr_valid = 0; csr_en = 0; funct3 = 0; csr_addr = 0; rs1_data = 0;
    rs1_field = 0; pc = 0; ecall = 0; mret = 0; ext_irq = 0;
    m_reset();
    @(posedge clk); #1;

    repeat (3) do_rst("reset");

    // Reset values.
    do_rd(12'h300, "rst_mstatus"); do_rd(12'h304, "rst_mie");   do_rd(12'h305, "rst_mtvec");
    do_rd(12'h340, "rst_mscratch"); do_rd(12'h341, "rst_mepc"); do_rd(12'h342, "rst_mcause");
    do_rd(12'hF14, "rst_mhartid"); do_rd(12'hB02, "rst_minstret"); do_rd(12'hB00, "rst_mcycle");

    // Read-modify-write on mscratch.
    do_csr(3'd1, 12'h340, 32'hDEAD_BEEF, 5'd1, 1'b0, "rw_mscratch");
    do_csr(3'd6, 12'h340, 32'h0,         5'd5, 1'b0, "rsi_mscratch");
    do_csr(3'd3, 12'h340, 32'h0000_000F, 5'd2, 1'b0, "rc_mscratch");
    do_rd(12'h340, "final_mscratch");

    // ecall / mret round trip.
    do_csr(3'd1, 12'h305, 32'h0000_0100, 5'd1, 1'b0, "wr_mtvec");
    do_csr(3'd1, 12'h300, 32'h0000_0008, 5'd1, 1'b0, "set_mie");
    do_sys(1, 0, 32'h0000_0040, 1'b0, 1'b1, "ecall");
    do_rd(12'h341, "ecall_mepc"); do_rd(12'h342, "ecall_mcause"); do_rd(12'h300, "ecall_mstatus");
    do_sys(0, 1, 32'h0000_0104, 1'b0, 1'b1, "mret");
    do_rd(12'h300, "mret_mstatus");

    // External interrupt against a csrrw, then the same with MIE=0.
    do_csr(3'd1, 12'h304, 32'h0000_0800, 5'd1, 1'b0, "set_meie");
    do_csr(3'd1, 12'h340, 32'h1234_5678, 5'd1, 1'b1, "irq_on_csrrw");
    do_rd(12'h342, "irq_mcause"); do_rd(12'h340, "irq_mscratch");
    do_csr(3'd1, 12'h340, 32'h1234_5678, 5'd1, 1'b1, "irq_masked");
    do_rd(12'h340, "masked_mscratch");
    do_rd(12'h344, "mip_low");
    do_csr(3'd1, 12'h344, 32'hFFFF_FFFF, 5'd1, 1'b1, "mip_write_ignored");
    // Interrupt beats mret, and beats an illegal access.
    do_csr(3'd1, 12'h300, 32'h0000_0008, 5'd1, 1'b0, "set_mie2");
    do_sys(0, 1, 32'h0000_0200, 1'b1, 1'b1, "irq_on_mret");
    do_rd(12'h300, "irq_mret_mstatus");
    do_csr(3'd1, 12'h300, 32'h0000_0008, 5'd1, 1'b0, "set_mie3");
    do_csr(3'd1, 12'hC00, 32'h1, 5'd1, 1'b1, "irq_over_illegal");
    do_rd(12'h342, "irq_over_illegal_mcause");

    // Illegal accesses and read-only rules.
    do_csr(3'd1, 12'hC00, 32'h5, 5'd1, 1'b0, "csrrw_cycle");
    do_rd(12'h342, "illegal_mcause");
    do_rd(12'hC00, "read_cycle");
    do_rd(12'h7FF, "read_unimpl");
    do_csr(3'd4, 12'h340, 32'h5, 5'd1, 1'b0, "funct3_zero");
    do_csr(3'd1, 12'hF14, 32'h5, 5'd1, 1'b0, "write_mhartid");
    do_csr(3'd3, 12'hF14, 32'h0, 5'd0, 1'b0, "rc0_mhartid");
    do_csr(3'd7, 12'hC82, 32'h0, 5'd0, 1'b0, "rci0_instreth");

    // Counter override and carry.
    do_csr(3'd1, 12'hB80, 32'h0,         5'd1, 1'b0, "wr_mcycleh");
    do_csr(3'd1, 12'hB00, 32'hFFFF_FFFF, 5'd1, 1'b0, "wr_mcycle");
    do_rd(12'hB00, "mcycle_override");
    do_rd(12'hB80, "mcycleh_carry");
    do_csr(3'd1, 12'hB02, 32'h0000_0005, 5'd1, 1'b0, "wr_minstret");
    do_rd(12'hB02, "minstret_override");
    do_sys(0, 1, 32'h0, 1'b1, 1'b0, "idle_mret");
    do_rd(12'hC02, "instret_after_idle");

    // Reset in the middle of activity.
    do_csr(3'd1, 12'h340, 32'h0000_00A5, 5'd1, 1'b0, "pre_reset_wr");
    do_rst("mid_reset");
    do_rd(12'h340, "post_reset_mscratch");
    do_rd(12'h305, "post_reset_mtvec");
    do_rd(12'hB00, "post_reset_mcycle");

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      int kind;
      s = '0;
      s.iv  = ($urandom_range(0, 7) != 0);
      s.irq = ($urandom_range(0, 3) == 0);
      s.pc  = $urandom;
      kind  = int'($urandom_range(0, 9));
      if (kind == 0) s.ec = 1;
      else if (kind == 1) s.mr = 1;
      else if (kind < 9) begin
        s.ce   = 1;
        s.f3   = 3'($urandom_range(0, 7));
        s.addr = addrs[$urandom_range(0, 17)];
        s.d    = $urandom;
        s.fld  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      end
      step(s, "rand");
    end

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      n_checks++;
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
